// File: rtl/switch_mcu_exec_sequencer_if.sv
// Instruction- and data-memory handshake bundle for the switch MCU
// exec sequencer.
//
//   out_imem_req   sequencer -> imem  fetch request, held until ack
//   out_imem_addr  sequencer -> imem  fetch address (current PC)
//   in_imem_ack    imem -> sequencer  fetch data valid this cycle
//   in_imem_rdata  imem -> sequencer  fetched instruction word
//   out_dmem_req   sequencer -> dmem  data access request, held until ack
//   in_dmem_ack    dmem -> sequencer  data access complete
//
// The master modport is the sequencer side; the slave modport is the
// memory side.
interface switch_mcu_exec_sequencer_if;
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_ack;
  logic [31:0] in_imem_rdata;
  logic        out_dmem_req;
  logic        in_dmem_ack;

  modport master (
    output out_imem_req,
    output out_imem_addr,
    input  in_imem_ack,
    input  in_imem_rdata,
    output out_dmem_req,
    input  in_dmem_ack
  );

  modport slave (
    input  out_imem_req,
    input  out_imem_addr,
    output in_imem_ack,
    output in_imem_rdata,
    input  out_dmem_req,
    output in_dmem_ack
  );
endinterface

// File: rtl/switch_mcu_exec_sequencer.sv
// Fetch/execute sequencer for the switch MCU core. Owns the PC and the
// instruction latch, runs the instruction fetch handshake, drives the
// decode/execute/writeback phase to the decoder and ALU, stalls on data
// memory accesses, applies branch redirects and handles halt/resume.
//
// Ports:
//   in_clk            core clock, rising edge
//   in_rst            synchronous active-low reset
//   in_run            level, start request sampled in IDLE
//   bus               imem/dmem handshake (master side)
//   out_inst          latched instruction
//   out_cycle_cnt     phase: 0 decode, 1 execute, 2 writeback, F none
//   out_pc_reg        PC of the instruction in flight
//   in_mem_op         decoded load/store, sampled in EXEC
//   in_branch_taken   redirect request, sampled in WB
//   in_branch_target  redirect address, sampled in WB
//   in_halt           decoded ecall/ebreak, sampled in WB
//   in_resume         leaves HALT
//   out_halted        high while halted
//   out_trap          sticky misaligned-redirect flag
//   out_retired_cnt   retired instruction count
module switch_mcu_exec_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0004
) (
  input  logic                               in_clk,
  input  logic                               in_rst,
  input  logic                               in_run,
  switch_mcu_exec_sequencer_if.master        bus,
  output logic [31:0]                        out_inst,
  output logic [3:0]                         out_cycle_cnt,
  output logic [31:0]                        out_pc_reg,
  input  logic                               in_mem_op,
  input  logic                               in_branch_taken,
  input  logic [31:0]                        in_branch_target,
  input  logic                               in_halt,
  input  logic                               in_resume,
  output logic                               out_halted,
  output logic                               out_trap,
  output logic [31:0]                        out_retired_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [3:0] PHASE_NONE = 4'hF;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] inst_next;
  logic        trap_next;
  logic [31:0] retired_next;
  logic [3:0]  cycle_next;
  logic [31:0] pc_plus4;

  assign pc_plus4          = out_pc_reg + 32'd4;
  assign bus.out_imem_addr = out_pc_reg;

  // State and every output are registered. Outputs are derived from the
  // next state so that they line up with the state they describe.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state            <= ST_IDLE;
      out_pc_reg       <= RESET_PC;
      out_inst         <= 32'd0;
      out_cycle_cnt    <= PHASE_NONE;
      bus.out_imem_req <= 1'b0;
      bus.out_dmem_req <= 1'b0;
      out_halted       <= 1'b0;
      out_trap         <= 1'b0;
      out_retired_cnt  <= 32'd0;
    end else begin
      state            <= state_next;
      out_pc_reg       <= pc_next;
      out_inst         <= inst_next;
      out_cycle_cnt    <= cycle_next;
      bus.out_imem_req <= (state_next == ST_FETCH);
      bus.out_dmem_req <= (state_next == ST_MEM);
      out_halted       <= (state_next == ST_HALT);
      out_trap         <= trap_next;
      out_retired_cnt  <= retired_next;
    end
  end

  // Next-state, PC, latch, trap and retire logic. In WB a halt wins over
  // a branch; a misaligned taken branch traps without retiring.
  always_comb begin
    state_next   = state;
    pc_next      = out_pc_reg;
    inst_next    = out_inst;
    trap_next    = out_trap;
    retired_next = out_retired_cnt;

    case (state)
      ST_IDLE: begin
        if (in_run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.in_imem_ack) begin
          inst_next  = bus.in_imem_rdata;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = in_mem_op ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (bus.in_dmem_ack) state_next = ST_WB;
      end
      ST_WB: begin
        if (in_halt) begin
          state_next   = ST_HALT;
          retired_next = out_retired_cnt + 32'd1;
        end else if (in_branch_taken && (in_branch_target[1:0] != 2'b00)) begin
          state_next = ST_HALT;
          trap_next  = 1'b1;
        end else begin
          state_next   = ST_FETCH;
          retired_next = out_retired_cnt + 32'd1;
          pc_next      = in_branch_taken ? in_branch_target : pc_plus4;
        end
      end
      ST_HALT: begin
        if (in_resume) begin
          state_next = ST_FETCH;
          pc_next    = pc_plus4;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Phase code presented to the decoder and ALU for the upcoming state.
  always_comb begin
    cycle_next = PHASE_NONE;
    case (state_next)
      ST_DECODE: cycle_next = 4'd0;
      ST_EXEC:   cycle_next = 4'd1;
      ST_WB:     cycle_next = 4'd2;
      default:   cycle_next = PHASE_NONE;
    endcase
  end

endmodule
